max4_bitserial_scanner: RTL and testbench

- Bit-serial maximum finder for four unsigned operands. It sits directly upstream of the four-flag done checker.
- It holds a 4-bit candidate mask and drives it out as cand[3:0]. The done checker reduces that mask to done_in, which this block consumes to terminate the scan early.
- Operands are scanned MSB-first. Candidates with a 0 bit are eliminated whenever some other remaining candidate has a 1 bit.
- When the scan ends, the block reports the index and value of the maximum with a one-cycle valid pulse.

---
 rtl/max4_bitserial_scanner_if.sv | 27 ++
 rtl/max4_bitserial_scanner.sv | 130 +++++++++++++
 tb/tb_max4_bitserial_scanner.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/max4_bitserial_scanner_if.sv
// Handshake and data bundle for the bit-serial max-of-four scanner.
// The slave side is the scanner; the master side drives operands and done_in.
interface max4_bitserial_scanner_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data_in0;
  logic [WIDTH-1:0] data_in1;
  logic [WIDTH-1:0] data_in2;
  logic [WIDTH-1:0] data_in3;
  logic [3:0]       cand;
  logic             done_in;
  logic             ready;
  logic             valid;
  logic [1:0]       max_index;
  logic [WIDTH-1:0] max_value;

  modport master (
    output start, data_in0, data_in1, data_in2, data_in3, done_in,
    input  cand, ready, valid, max_index, max_value
  );

  modport slave (
    input  start, data_in0, data_in1, data_in2, data_in3, done_in,
    output cand, ready, valid, max_index, max_value
  );
endinterface

// File: rtl/max4_bitserial_scanner.sv
// MSB-first bit-serial maximum finder over four unsigned operands.
// Scan ends early once the external done checker reports a one-hot candidate mask.
module max4_bitserial_scanner #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input logic                     clk,
  input logic                     rst,
  max4_bitserial_scanner_if.slave scan_if
);

  typedef enum logic [1:0] {StIdle, StScan, StFinish} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q [4];
  logic [WIDTH-1:0] shift_d [4];
  logic [WIDTH-1:0] cap_q   [4];
  logic [WIDTH-1:0] cap_d   [4];
  logic [WIDTH-1:0] data_in [4];
  logic [3:0]       msb;
  logic             any1;
  logic [1:0]       max_index_q, max_index_d;
  logic [WIDTH-1:0] max_value_q, max_value_d;
  logic             ready, valid;

  assign data_in[0] = scan_if.data_in0;
  assign data_in[1] = scan_if.data_in1;
  assign data_in[2] = scan_if.data_in2;
  assign data_in[3] = scan_if.data_in3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (scan_if.start) state_d = StScan;
      StScan:   if (scan_if.done_in || cnt_q == '0) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = (state_q == StIdle);
    valid = (state_q == StFinish);
  end

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 4; i++) begin
      shift_d[i] = shift_q[i];
      cap_d[i]   = cap_q[i];
      msb[i]     = shift_q[i][WIDTH-1];
    end
    any1 = |(cand_q & msb);
    unique case (state_q)
      StIdle: begin
        if (scan_if.start) begin
          for (int i = 0; i < 4; i++) begin
            shift_d[i] = data_in[i];
            cap_d[i]   = data_in[i];
          end
          cand_d = 4'hF;
          cnt_d  = CNT_W'(WIDTH - 1);
        end
      end
      StScan: begin
        if (!scan_if.done_in) begin
          // Only eliminate when a surviving candidate has a 1, so cand never empties.
          if (any1) cand_d = cand_q & msb;
          for (int i = 0; i < 4; i++) shift_d[i] = shift_q[i] << 1;
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
      end
      StFinish: cand_d = '0;
      default:  cand_d = '0;
    endcase
  end

  // Result is latched on entry to FINISH from the final mask; lowest index wins ties.
  always_comb begin
    max_index_d = max_index_q;
    max_value_d = max_value_q;
    if (state_q == StScan && state_d == StFinish) begin
      max_index_d = '0;
      for (int i = 3; i >= 0; i--) begin
        if (cand_d[i]) max_index_d = 2'(i);
      end
      max_value_d = cap_q[max_index_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q      <= '0;
      cnt_q       <= '0;
      max_index_q <= '0;
      max_value_q <= '0;
      for (int i = 0; i < 4; i++) begin
        shift_q[i] <= '0;
        cap_q[i]   <= '0;
      end
    end else begin
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      max_index_q <= max_index_d;
      max_value_q <= max_value_d;
      for (int i = 0; i < 4; i++) begin
        shift_q[i] <= shift_d[i];
        cap_q[i]   <= cap_d[i];
      end
    end
  end

  assign scan_if.cand      = cand_q;
  assign scan_if.ready     = ready;
  assign scan_if.valid     = valid;
  assign scan_if.max_index = max_index_q;
  assign scan_if.max_value = max_value_q;

endmodule

// File: tb/tb_max4_bitserial_scanner.sv
// Directed bench for max4_bitserial_scanner; the done checker is modelled as
// "cand is one-hot or zero".
module tb_max4_bitserial_scanner;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  max4_bitserial_scanner_if #(.WIDTH(8)) scan_if ();

  max4_bitserial_scanner #(.WIDTH(8), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .scan_if (scan_if)
  );

  assign scan_if.done_in = ((scan_if.cand & (scan_if.cand - 4'd1)) == 4'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Starts one scan from IDLE and watches 40 cycles; cycle 0 follows the accepting edge.
  task automatic do_scan(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, output int first_v, output int nv,
                         output logic [1:0] idx, output logic [7:0] val,
                         output logic [3:0] cand0, output logic [3:0] cand1,
                         output logic [3:0] cand_fin, output logic rdy0,
                         output logic rdy_after);
    scan_if.data_in0 = a;
    scan_if.data_in1 = b;
    scan_if.data_in2 = c;
    scan_if.data_in3 = d;
    scan_if.start    = 1'b1;
    @(posedge clk); #1;
    scan_if.start = 1'b0;
    first_v   = -1;
    nv        = 0;
    idx       = 'x;
    val       = 'x;
    cand0     = 'x;
    cand1     = 'x;
    cand_fin  = 'x;
    rdy0      = 1'bx;
    rdy_after = 1'bx;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 0) begin
        cand0 = scan_if.cand;
        rdy0  = scan_if.ready;
      end
      if (cyc == 1) cand1 = scan_if.cand;
      if (scan_if.valid === 1'b1) begin
        nv++;
        if (first_v < 0) begin
          first_v  = cyc;
          idx      = scan_if.max_index;
          val      = scan_if.max_value;
          cand_fin = scan_if.cand;
        end
      end
      if (first_v >= 0 && cyc == first_v + 1) rdy_after = scan_if.ready;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    scan_if.start    = 1'b1;
    scan_if.data_in0 = 8'hAA;
    scan_if.data_in1 = 8'h55;
    scan_if.data_in2 = 8'h0F;
    scan_if.data_in3 = 8'hF0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (scan_if.cand !== 4'h0) begin errors++;
      $display("FAIL reset_cand: got %h expected 0", scan_if.cand); end
    checks++; if (scan_if.ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b expected 1", scan_if.ready); end
    checks++; if (scan_if.valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b expected 0", scan_if.valid); end
    checks++; if (scan_if.max_index !== 2'd0 || scan_if.max_value !== 8'h00) begin errors++;
      $display("FAIL reset_result: got %0d/%h expected 0/00",
               scan_if.max_index, scan_if.max_value); end
    scan_if.start = 1'b0;
    rst           = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_early_exit();
    int f, n; logic [1:0] ix; logic [7:0] v; logic [3:0] c0, c1, cf; logic r0, ra;
    do_scan(8'h10, 8'h80, 8'h40, 8'h20, f, n, ix, v, c0, c1, cf, r0, ra);
    checks++; if (c0 !== 4'hF) begin errors++;
      $display("FAIL early_cand0: got %h expected f", c0); end
    checks++; if (c1 !== 4'b0010) begin errors++;
      $display("FAIL early_cand1: got %b expected 0010", c1); end
    checks++; if (r0 !== 1'b0) begin errors++;
      $display("FAIL early_ready_scan: got %b expected 0", r0); end
    checks++; if (f !== 2) begin errors++;
      $display("FAIL early_latency: got %0d expected 2", f); end
    checks++; if (n !== 1) begin errors++;
      $display("FAIL early_pulses: got %0d expected 1", n); end
    checks++; if (ix !== 2'd1 || v !== 8'h80) begin errors++;
      $display("FAIL early_result: got %0d/%h expected 1/80", ix, v); end
    checks++; if (ra !== 1'b1) begin errors++;
      $display("FAIL early_ready_after: got %b expected 1", ra); end
    checks++; if (scan_if.max_index !== 2'd1 || scan_if.max_value !== 8'h80) begin errors++;
      $display("FAIL early_hold: got %0d/%h expected 1/80",
               scan_if.max_index, scan_if.max_value); end
  endtask

  task automatic test_full_scan();
    int f, n; logic [1:0] ix; logic [7:0] v; logic [3:0] c0, c1, cf; logic r0, ra;
    do_scan(8'h55, 8'h55, 8'h55, 8'h55, f, n, ix, v, c0, c1, cf, r0, ra);
    checks++; if (cf !== 4'hF || c1 !== 4'hF) begin errors++;
      $display("FAIL eq_cand: got %h/%h expected f/f", c1, cf); end
    checks++; if (f !== 8 || n !== 1) begin errors++;
      $display("FAIL eq_latency: got %0d/%0d expected 8/1", f, n); end
    checks++; if (ix !== 2'd0 || v !== 8'h55) begin errors++;
      $display("FAIL eq_result: got %0d/%h expected 0/55", ix, v); end

    do_scan(8'h00, 8'h00, 8'h00, 8'h00, f, n, ix, v, c0, c1, cf, r0, ra);
    checks++; if (cf !== 4'hF || f !== 8) begin errors++;
      $display("FAIL zero_scan: got %h/%0d expected f/8", cf, f); end
    checks++; if (ix !== 2'd0 || v !== 8'h00) begin errors++;
      $display("FAIL zero_result: got %0d/%h expected 0/00", ix, v); end

    do_scan(8'hF0, 8'hF1, 8'h0F, 8'hF1, f, n, ix, v, c0, c1, cf, r0, ra);
    checks++; if (c1 !== 4'b1011) begin errors++;
      $display("FAIL tie_cand1: got %b expected 1011", c1); end
    checks++; if (cf !== 4'b1010) begin errors++;
      $display("FAIL tie_cand_fin: got %b expected 1010", cf); end
    checks++; if (f !== 8 || n !== 1) begin errors++;
      $display("FAIL tie_latency: got %0d/%0d expected 8/1", f, n); end
    checks++; if (ix !== 2'd1 || v !== 8'hF1) begin errors++;
      $display("FAIL tie_result: got %0d/%h expected 1/f1", ix, v); end
  endtask

  task automatic test_back_to_back();
    int nv, nrdy, dbl, v0, v1, bad;
    logic prev;
    nv = 0; nrdy = 0; dbl = 0; v0 = -1; v1 = -1; bad = 0; prev = 1'b0;
    scan_if.data_in0 = 8'h01;
    scan_if.data_in1 = 8'h02;
    scan_if.data_in2 = 8'h03;
    scan_if.data_in3 = 8'h04;
    scan_if.start    = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (scan_if.ready === 1'b1) nrdy++;
      if (scan_if.valid === 1'b1) begin
        if (prev) dbl++;
        if (nv == 0) v0 = cyc;
        if (nv == 1) v1 = cyc;
        nv++;
        if (scan_if.max_index !== 2'd3 || scan_if.max_value !== 8'h04) bad++;
      end
      prev = scan_if.valid;
      @(posedge clk); #1;
    end
    scan_if.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (v0 !== 7 || v1 !== 16) begin errors++;
      $display("FAIL b2b_timing: got %0d/%0d expected 7/16", v0, v1); end
    checks++; if (nv !== 4) begin errors++;
      $display("FAIL b2b_pulses: got %0d expected 4", nv); end
    checks++; if (dbl !== 0) begin errors++;
      $display("FAIL b2b_pulse_width: got %0d wide expected 0", dbl); end
    checks++; if (nrdy !== 4) begin errors++;
      $display("FAIL b2b_ready_cycles: got %0d expected 4", nrdy); end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL b2b_result: got %0d bad results expected 0", bad); end
    checks++; if (scan_if.ready !== 1'b1) begin errors++;
      $display("FAIL b2b_idle: got %b expected 1", scan_if.ready); end
  endtask

  task automatic test_mid_reset();
    int seen;
    int f, n; logic [1:0] ix; logic [7:0] v; logic [3:0] c0, c1, cf; logic r0, ra;
    seen = 0;
    scan_if.data_in0 = 8'h55;
    scan_if.data_in1 = 8'h55;
    scan_if.data_in2 = 8'h55;
    scan_if.data_in3 = 8'h55;
    scan_if.start    = 1'b1;
    @(posedge clk); #1;
    scan_if.start = 1'b0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      if (scan_if.valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (scan_if.cand !== 4'h0 || scan_if.ready !== 1'b1) begin errors++;
      $display("FAIL midrst_state: got %h/%b expected 0/1", scan_if.cand, scan_if.ready); end
    checks++; if (scan_if.max_index !== 2'd0 || scan_if.max_value !== 8'h00) begin errors++;
      $display("FAIL midrst_result: got %0d/%h expected 0/00",
               scan_if.max_index, scan_if.max_value); end
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (scan_if.valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++;
      $display("FAIL midrst_no_valid: got %0d pulses expected 0", seen); end

    do_scan(8'h11, 8'h22, 8'h33, 8'h30, f, n, ix, v, c0, c1, cf, r0, ra);
    checks++; if (c1 !== 4'hF || cf !== 4'b0100) begin errors++;
      $display("FAIL fresh_cand: got %h/%b expected f/0100", c1, cf); end
    checks++; if (f !== 8 || n !== 1) begin errors++;
      $display("FAIL fresh_latency: got %0d/%0d expected 8/1", f, n); end
    checks++; if (ix !== 2'd2 || v !== 8'h33) begin errors++;
      $display("FAIL fresh_result: got %0d/%h expected 2/33", ix, v); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_early_exit();
    test_full_scan();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
